// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared constants and types for the sequential 32-bit
//                restoring divider (widths, FSM state encoding and the
//                quotient value reported on divide-by-zero).
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   // FIX is only reachable when the signed build is enabled.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT = '1;

endpackage
`default_nettype wire

// File: rtl/divider_sub_stage.sv
`default_nettype none
// ============================================================================
//  Module      : divider_sub_stage
//  Description : Combinational (WIDTH+1)-bit trial subtractor used by one
//                restoring-division iteration. diff = x + ~y + 1; the carry
//                out of that sum is reported as no_borrow (x >= y).
//  Ports       : x, y      - (WIDTH+1)-bit operands
//                diff      - (WIDTH+1)-bit difference
//                no_borrow - carry out, high when x >= y
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_sub_stage
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0] x,
   input  logic [WIDTH:0] y,
   output logic [WIDTH:0] diff,
   output logic           no_borrow
);

   // One extra bit on each operand captures the carry out of the addition.
   assign {no_borrow, diff} = {1'b0, x} + {1'b0, ~y} + {{(WIDTH + 1){1'b0}}, 1'b1};

endmodule
`default_nettype wire

// File: rtl/divider_32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divider_32_seq
//  Description : Multi-cycle restoring divider, one quotient bit per clock.
//                start/busy/done handshake; quot/rem/dz/v are registered and
//                held until the next result is produced.
//                Optional build macro DIVIDER_SIGNED_EN adds the is_signed
//                input and a FIX cycle applying result signs; without it all
//                operations are unsigned and v is tied low.
//  Ports       : clk, reset (sync, active high)
//                start, a (dividend), b (divisor) [, is_signed]
//                busy, done (1-cycle pulse), quot, rem, dz, v
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_32_seq
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef DIVIDER_SIGNED_EN
   input  logic             is_signed,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             dz,
   output logic             v
);

   div_state_e       state_q;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] b_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             dz_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;

   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   t_diff;
   logic             t_ok;
   logic [WIDTH-1:0] p_d;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             w_unused_t_msb;

   // {P,Q} shifted left by one: the next dividend bit enters P.
   assign p_shift = {p_q, q_q[WIDTH-1]};

   divider_sub_stage #(
      .WIDTH (WIDTH)
   ) u_sub (
      .x         (p_shift),
      .y         ({1'b0, b_q}),
      .diff      (t_diff),
      .no_borrow (t_ok)
   );

   // P < b holds between iterations, so the kept remainder always fits WIDTH bits.
   assign p_d            = t_ok ? t_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
   assign q_d            = {q_q[WIDTH-2:0], t_ok};
   assign w_unused_t_msb = t_diff[WIDTH];

`ifdef DIVIDER_SIGNED_EN
   logic neg_a;
   logic neg_b;
   logic ovf;
   logic neg_rem_q;
   logic neg_quot_q;
   logic ovf_q;
   logic v_q;

   assign neg_a = is_signed & a[WIDTH-1];
   assign neg_b = is_signed & b[WIDTH-1];
   assign a_mag = neg_a ? -a : a;
   assign b_mag = neg_b ? -b : b;
   // Most-negative / -1 is the only signed quotient that does not fit.
   assign ovf   = is_signed && (a == {1'b1, {(WIDTH - 1){1'b0}}}) && (b == '1);
   assign v     = v_q;
`else
   assign a_mag = a;
   assign b_mag = b;
   assign v     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         p_q     <= '0;
         q_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
`ifdef DIVIDER_SIGNED_EN
         neg_rem_q  <= 1'b0;
         neg_quot_q <= 1'b0;
         ovf_q      <= 1'b0;
         v_q        <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  p_q   <= '0;
                  q_q   <= a_mag;
                  b_q   <= b_mag;
                  cnt_q <= CNT_W'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
                  neg_rem_q  <= neg_a;
                  neg_quot_q <= neg_a ^ neg_b;
                  ovf_q      <= ovf;
`endif
                  if (b == '0) begin
                     // Divide-by-zero completes immediately, no iterations.
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     quot_q  <= WIDTH'(DIV_DZ_QUOT);
                     rem_q   <= a;
                     dz_q    <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
                     v_q     <= 1'b0;
`endif
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               p_q   <= p_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
`ifdef DIVIDER_SIGNED_EN
                  state_q <= FIX;
`else
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  quot_q  <= q_d;
                  rem_q   <= p_d;
                  dz_q    <= 1'b0;
`endif
               end
            end
`ifdef DIVIDER_SIGNED_EN
            FIX: begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               quot_q  <= neg_quot_q ? -q_q : q_q;
               rem_q   <= neg_rem_q ? -p_q : p_q;
               dz_q    <= 1'b0;
               v_q     <= ovf_q;
            end
`endif
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;
   assign rem  = rem_q;
   assign dz   = dz_q;

endmodule
`default_nettype wire
